// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: widths, source encodings, default FIFO depth.
// Build option: define WB_ROUND_ROBIN_EN for MEM/MDU round-robin; otherwise MEM has fixed priority.
package wb_arbiter_pkg;

    localparam int WB_AW         = 5;
    localparam int WB_DW         = 32;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int NUM_REGS      = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_MDU  = 2'd3
    } src_e;

    typedef enum logic {
        RR_MEM = 1'b0,
        RR_MDU = 1'b1
    } rr_e;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO of {waddr, wdata} entries; exports per-entry valid/address for hazard tracking.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pushValid_i,
    output logic                      pushReady_o,
    input  logic [AW-1:0]             pushAddr_i,
    input  logic [DW-1:0]             pushData_i,
    input  logic                      pop_i,
    output logic                      empty_o,
    output logic [AW-1:0]             headAddr_o,
    output logic [DW-1:0]             headData_o,
    output logic [DEPTH-1:0]          entryValid_o,
    output logic [DEPTH-1:0][AW-1:0]  entryAddr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addrMem_q;
    logic [DEPTH-1:0][DW-1:0] dataMem_q;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [PW-1:0]            wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     full, doPush, doPop;

    // Ready depends only on occupancy; writes to r0 are handshaken but dropped.
    assign full        = (count_q == CW'(DEPTH));
    assign pushReady_o = !full;
    assign empty_o     = (count_q == '0);
    assign doPush      = pushValid_i && !full && (pushAddr_i != '0);
    assign doPop       = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        valid_d = valid_q;
        count_d = count_q + CW'(doPush) - CW'(doPop);
        if (doPop) begin
            valid_d[rdPtr_q] = 1'b0;
            rdPtr_d          = rdPtr_q + PW'(1);
        end
        if (doPush) begin
            valid_d[wrPtr_q] = 1'b1;
            wrPtr_d          = wrPtr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem_q[wrPtr_q] <= pushAddr_i;
            dataMem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign headAddr_o   = addrMem_q[rdPtr_q];
    assign headData_o   = dataMem_q[rdPtr_q];
    assign entryValid_o = valid_q;
    assign entryAddr_o  = addrMem_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU writes directly, MEM/MDU results buffered and drained into idle slots.
// Build option WB_ROUND_ROBIN_EN selects MEM/MDU round-robin; default is fixed MEM-over-MDU priority.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int AW         = WB_AW,
    parameter int DW         = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_we,
    input  logic [AW-1:0] alu_waddr,
    input  logic [DW-1:0] alu_wdata,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [AW-1:0] mdu_waddr,
    input  logic [DW-1:0] mdu_wdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [31:0]   pend_mask,
    output logic          idle
);

    logic                          memEmpty, mduEmpty, memPop, mduPop, aluHit;
    logic [AW-1:0]                 memHeadAddr, mduHeadAddr;
    logic [DW-1:0]                 memHeadData, mduHeadData;
    logic [FIFO_DEPTH-1:0]         memEntryValid, mduEntryValid;
    logic [FIFO_DEPTH-1:0][AW-1:0] memEntryAddr, mduEntryAddr;
    logic                          rfWe_q, rfWe_d;
    logic [AW-1:0]                 rfWaddr_q, rfWaddr_d;
    logic [DW-1:0]                 rfWdata_q, rfWdata_d;
    logic [31:0]                   pendMask;
    src_e                          sel;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW), .DW(DW)) memFifo (
        .clk(clk), .rst(rst),
        .pushValid_i(mem_valid), .pushReady_o(mem_ready),
        .pushAddr_i(mem_waddr), .pushData_i(mem_wdata),
        .pop_i(memPop), .empty_o(memEmpty),
        .headAddr_o(memHeadAddr), .headData_o(memHeadData),
        .entryValid_o(memEntryValid), .entryAddr_o(memEntryAddr)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW), .DW(DW)) mduFifo (
        .clk(clk), .rst(rst),
        .pushValid_i(mdu_valid), .pushReady_o(mdu_ready),
        .pushAddr_i(mdu_waddr), .pushData_i(mdu_wdata),
        .pop_i(mduPop), .empty_o(mduEmpty),
        .headAddr_o(mduHeadAddr), .headData_o(mduHeadData),
        .entryValid_o(mduEntryValid), .entryAddr_o(mduEntryAddr)
    );

    assign aluHit = alu_we && (alu_waddr != '0);

`ifdef WB_ROUND_ROBIN_EN
    rr_e rrPtr_q, rrPtr_d;

    always_ff @(posedge clk) begin
        if (rst) rrPtr_q <= RR_MEM;
        else     rrPtr_q <= rrPtr_d;
    end

    // After a FIFO grant the other source gets first claim next time.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (sel == SRC_MEM)      rrPtr_d = RR_MDU;
        else if (sel == SRC_MDU) rrPtr_d = RR_MEM;
    end

    always_comb begin
        sel = SRC_NONE;
        if (aluHit)                                          sel = SRC_ALU;
        else if (!memEmpty && (mduEmpty || rrPtr_q == RR_MEM)) sel = SRC_MEM;
        else if (!mduEmpty)                                  sel = SRC_MDU;
    end
`else
    always_comb begin
        sel = SRC_NONE;
        if (aluHit)         sel = SRC_ALU;
        else if (!memEmpty) sel = SRC_MEM;
        else if (!mduEmpty) sel = SRC_MDU;
    end
`endif

    always_comb begin
        rfWe_d    = 1'b0;
        rfWaddr_d = rfWaddr_q;
        rfWdata_d = rfWdata_q;
        memPop    = 1'b0;
        mduPop    = 1'b0;
        unique case (sel)
            SRC_ALU: begin
                rfWe_d = 1'b1; rfWaddr_d = alu_waddr; rfWdata_d = alu_wdata;
            end
            SRC_MEM: begin
                rfWe_d = 1'b1; rfWaddr_d = memHeadAddr; rfWdata_d = memHeadData; memPop = 1'b1;
            end
            SRC_MDU: begin
                rfWe_d = 1'b1; rfWaddr_d = mduHeadAddr; rfWdata_d = mduHeadData; mduPop = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rfWe_q    <= 1'b0;
            rfWaddr_q <= '0;
            rfWdata_q <= '0;
        end else begin
            rfWe_q    <= rfWe_d;
            rfWaddr_q <= rfWaddr_d;
            rfWdata_q <= rfWdata_d;
        end
    end

    // Register 0 is never written, so its pending bit stays clear.
    always_comb begin
        pendMask = '0;
        for (int r = 1; r < 32; r++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if ((memEntryValid[e] && memEntryAddr[e] == AW'(r)) ||
                    (mduEntryValid[e] && mduEntryAddr[e] == AW'(r)))
                    pendMask[r] = 1'b1;
            end
            if (rfWe_q && rfWaddr_q == AW'(r)) pendMask[r] = 1'b1;
        end
    end

    assign rf_we     = rfWe_q;
    assign rf_waddr  = rfWaddr_q;
    assign rf_wdata  = rfWdata_q;
    assign pend_mask = pendMask;
    assign idle      = memEmpty && mduEmpty && !rfWe_q;

endmodule
